// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that fills instruction memory and holds the core in reset until done
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_request,
  output logic              mem_re_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t              state, next_state;
  logic [1:0]          byte_cnt;
  logic [31:0]         word_count;
  logic [31:0]         asm_word;
  logic [ADDR_W-1:0]   word_index;
  logic [7:0]          xor_sum;
  logic                accept;
  logic                last_byte;
  logic                restart;
  logic [31:0]         hdr_full;
  logic [31:0]         data_full;

  assign accept    = byte_valid && byte_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  // Bytes arrive LSB first, so each new byte shifts in from the top.
  assign hdr_full  = {byte_data, word_count[31:8]};
  assign data_full = {byte_data, asm_word[31:8]};

  assign mem_request = (state == S_WRITE);
  assign mem_re_we   = (state == S_WRITE);
  assign mem_mask    = {4{state == S_WRITE}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_HDR;
      S_HDR: begin
        byte_ready = 1'b1;
        if (accept && last_byte) begin
          if (hdr_full == 32'd0)              next_state = S_FINISH;
          else if (hdr_full > 32'(DEPTH))     next_state = S_ERR;
          else                                next_state = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (accept && last_byte) next_state = S_WRITE;
      end
      S_WRITE: begin
        if (32'(word_index) + 32'd1 == word_count) next_state = S_FINISH;
        else                                       next_state = S_DATA;
      end
      S_DONE: if (start) next_state = S_HDR;
      S_ERR:  if (start) next_state = S_HDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (accept) next_state = (byte_data == xor_sum) ? S_DONE : S_ERR;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= 2'd0;
      word_count  <= 32'd0;
      asm_word    <= 32'd0;
      word_index  <= '0;
      xor_sum     <= 8'd0;
      mem_address <= '0;
      mem_data_in <= 32'd0;
      core_rst    <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // Status flags are registered from next_state so core_rst never glitches.
      core_rst <= (next_state != S_DONE);
      done     <= (next_state == S_DONE);
      error    <= (next_state == S_ERR);
      if (restart) begin
        byte_cnt   <= 2'd0;
        word_count <= 32'd0;
        asm_word   <= 32'd0;
        word_index <= '0;
        xor_sum    <= 8'd0;
      end else if (state == S_WRITE) begin
        word_index <= word_index + 1'b1;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_HDR) word_count <= hdr_full;
        if (state == S_DATA) begin
          asm_word <= data_full;
          xor_sum  <= xor_sum ^ byte_data;
          if (last_byte) begin
            mem_address <= word_index;
            mem_data_in <= data_full;
          end
        end
      end
    end
  end

endmodule
